fifo_wr_arbiter: RTL and testbench
==================================

// Module: fifo_wr_arbiter
// PURPOSE
//  Shares the write port of one syn_fifo between N producers.
//  Round-robin arbitration; a winner keeps the port for a burst of up to MAX_BURST beats.
//  Never writes into a full FIFO, so no beat is silently dropped.
//  Sits between the producer blocks and the FIFO: drives its w_en/data_in and observes its full.
// PARAMETERS
//  N_REQ      4  number of producers (>=2)
//  DATA_WIDTH 8  beat width; equals the FIFO DATA_WIDTH
//  MAX_BURST  4  maximum beats per grant (>=1); 1 gives pure per-beat round-robin
// PORTS
//  clk           in   1              rising-edge clock
//  rst_n         in   1              asynchronous active-low reset
//  req           in   N_REQ          per-producer "beat valid"; held until its gnt bit pulses
//  req_data      in   N_REQ*DATA_WIDTH  producer i's beat in slice [i*DW +: DW]
//  gnt           out  N_REQ          one-hot; bit i = producer i's beat accepted this cycle
//  fifo_full     in   1              FIFO full flag
//  fifo_w_en     out  1              FIFO write enable
//  fifo_data_in  out  DATA_WIDTH     FIFO write data
//  busy          out  1              high while in BURST
//  owner         out  $clog2(N_REQ)  current or last burst owner
// BEHAVIOUR
//  - Reset, asynchronous: state=IDLE, rr_ptr=0, owner=0, beat_cnt=0.
//    gnt=0, fifo_w_en=0, fifo_data_in=0, busy=0.
//  - Outputs are combinational from state and inputs: zero-latency handshake.
//    A beat is accepted in the same cycle that req is high and gnt pulses.
//  - fifo_w_en = |gnt. fifo_data_in = req_data slice of the granted producer, else 0.
//  - Invariants: gnt is never set while fifo_full=1; at most one gnt bit is set.
//  - IDLE:
//    - winner = first set req bit, searching from rr_ptr upward and wrapping N_REQ-1 -> 0.
//    - No req: stay in IDLE.
//    - req with fifo_full=1: no grant; stay in IDLE; rr_ptr unchanged. Winner is recomputed next cycle.
//    - req with fifo_full=0: gnt[winner]=1; owner<=winner; beat_cnt<=1.
//      - MAX_BURST==1: stay in IDLE, rr_ptr<=winner+1 (mod N_REQ).
//      - Otherwise go to BURST.
//  - BURST:
//    - req[owner]=1 and fifo_full=0: gnt[owner]=1; beat_cnt++.
//      If beat_cnt+1==MAX_BURST: go to IDLE, rr_ptr<=owner+1.
//    - req[owner]=1 and fifo_full=1: stall. No grant; beat_cnt and owner hold.
//    - req[owner]=0: no grant this cycle (one bubble); go to IDLE, rr_ptr<=owner+1.
//    - Other producers' req bits are ignored in BURST.
//  - Wrap: rr_ptr and owner+1 wrap modulo N_REQ; N_REQ need not be a power of 2.
//    beat_cnt width is $clog2(MAX_BURST+1).
//  - Reset asserted mid-burst: immediate return to the reset values.
//    Beats the FIFO already accepted stay in the FIFO.
//  - Fairness: every continuously requesting producer is granted within
//    (N_REQ-1)*MAX_BURST accepted beats of other producers.
// STRUCTURE
//  - fifo_arb_pkg: typedef enum logic {IDLE, BURST} arb_state_t.
//    Also a function rr_pick(req, ptr) returning {found, index}.
//  - Sub-module rr_priority_picker (N_REQ): combinational rotate, priority-encode, unrotate.
//  - Top level: state/rr_ptr/owner/beat_cnt registers, grant logic, data mux.
// TESTING (N_REQ=4, DATA_WIDTH=8, MAX_BURST=4, syn_fifo DEPTH=8 attached)
//  - Reset: rst_n low mid-burst with fifo_full=0 and req=4'b0010 held.
//    gnt=0, fifo_w_en=0, busy=0 immediately, without waiting for a clk edge.
//  - Single producer: req=4'b0100 held, data 0x30..0x35, 6 beats.
//    gnt[2] on 4 consecutive cycles, then 1 IDLE arbitration cycle re-grants 2.
//    FIFO receives 0x30..0x35 in order.
//  - Round-robin: req=4'b1111 held, FIFO drained every cycle.
//    Owners 0,1,2,3,0, 4 beats each.
//  - Early release: producer 1 drops req after 2 beats with req[3] high.
//    One cycle with no gnt; next grant goes to 3.
//  - Full stall: fifo_full forced 1 for 3 cycles mid-burst.
//    No gnt and no w_en; beat_cnt holds; burst resumes at the same beat.
//  - Random req/full for 10k cycles, scoreboard per producer.
//    No lost or duplicated beats; gnt is one-hot-or-zero; never w_en&&full.
//    Each producer's starvation bound is <= 12 accepted beats.

Source files
------------

// File: rtl/fifo_arb_pkg.sv
// Shared types and helpers for the FIFO write-port arbiter.
package fifo_arb_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } arb_state_t;

    localparam int unsigned RR_MAX_REQ = 32;
    localparam int unsigned RR_IDX_W   = 5;

    typedef struct packed {
        logic                found;
        logic [RR_IDX_W-1:0] index;
    } rr_pick_t;

    // (a + b) mod n, assuming a < n and b < n, so one subtraction is enough.
    function automatic int unsigned rr_wrap_add(input int unsigned a,
                                                input int unsigned b,
                                                input int unsigned n);
        int unsigned s;
        s = a + b;
        if (s >= n) s = s - n;
        return s;
    endfunction

    // Reference round-robin search: first set bit of req[n-1:0] at or above
    // ptr, wrapping n-1 -> 0. Returns {found, index}.
    function automatic rr_pick_t rr_pick(input logic [RR_MAX_REQ-1:0] req,
                                         input int unsigned n,
                                         input int unsigned ptr);
        rr_pick_t    res;
        int unsigned j;
        res = '0;
        for (int unsigned k = 0; k < RR_MAX_REQ; k++) begin
            if (k < n && !res.found) begin
                j = rr_wrap_add(ptr, k, n);
                if (req[RR_IDX_W'(j)]) begin
                    res.found = 1'b1;
                    res.index = RR_IDX_W'(j);
                end
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/fifo_wr_arbiter_picker.sv
// Round-robin priority picker: rotate requests so the pointer lands on bit 0,
// priority-encode the lowest set bit, then rotate the index back.
module rr_priority_picker
    import fifo_arb_pkg::*;
#(
    parameter int N_REQ = 4
) (
    input  logic [N_REQ-1:0]         req_i,
    input  logic [$clog2(N_REQ)-1:0] ptr_i,
    output logic                     found_o,
    output logic [$clog2(N_REQ)-1:0] idx_o
);

    localparam int PW = $clog2(N_REQ);

    logic [N_REQ-1:0] rot;
    logic [PW-1:0]    rot_idx;

    // Rotate requests so position ptr_i becomes bit 0 (wraps for any N_REQ).
    always_comb begin
        rot = '0;
        for (int i = 0; i < N_REQ; i++) begin
            rot[i] = req_i[PW'(rr_wrap_add(32'(ptr_i), i, N_REQ))];
        end
    end

    // Lowest set bit of the rotated vector is the closest requester to ptr_i.
    always_comb begin
        found_o = 1'b0;
        rot_idx = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (rot[i]) begin
                found_o = 1'b1;
                rot_idx = PW'(i);
            end
        end
    end

    assign idx_o = PW'(rr_wrap_add(32'(ptr_i), 32'(rot_idx), N_REQ));

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Shares one FIFO write port between N_REQ producers. Round-robin winner keeps
// the port for up to MAX_BURST beats; no beat is issued while the FIFO is full.
// Handshake: a producer holds req[i] with its beat on req_data until gnt[i]
// pulses; the beat is written to the FIFO in that same cycle (zero latency).
module fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int N_REQ      = 4,
    parameter int DATA_WIDTH = 8,
    parameter int MAX_BURST  = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [N_REQ-1:0]              req,
    input  logic [N_REQ*DATA_WIDTH-1:0]   req_data,
    output logic [N_REQ-1:0]              gnt,
    input  logic                          fifo_full,
    output logic                          fifo_w_en,
    output logic [DATA_WIDTH-1:0]         fifo_data_in,
    output logic                          busy,
    output logic [$clog2(N_REQ)-1:0]      owner
);

    localparam int PW = $clog2(N_REQ);
    localparam int BW = $clog2(MAX_BURST + 1);
    localparam logic [BW-1:0] LAST_BEAT = BW'(MAX_BURST);
    localparam logic [BW-1:0] ONE_BEAT  = BW'(1);

    arb_state_t       state_q, state_d;
    logic [PW-1:0]    rr_ptr_q, rr_ptr_d;
    logic [PW-1:0]    owner_q, owner_d;
    logic [BW-1:0]    beat_cnt_q, beat_cnt_d;
    logic [N_REQ-1:0] gnt_c;
    logic             pick_found;
    logic [PW-1:0]    pick_idx;
    logic [PW-1:0]    owner_next;
    logic [PW-1:0]    pick_next;

    rr_priority_picker #(.N_REQ(N_REQ)) u_picker (
        .req_i   (req),
        .ptr_i   (rr_ptr_q),
        .found_o (pick_found),
        .idx_o   (pick_idx)
    );

    assign owner_next = PW'(rr_wrap_add(32'(owner_q), 1, N_REQ));
    assign pick_next  = PW'(rr_wrap_add(32'(pick_idx), 1, N_REQ));

    // Grant and next-state decision; other requesters are ignored mid-burst.
    always_comb begin
        state_d    = state_q;
        rr_ptr_d   = rr_ptr_q;
        owner_d    = owner_q;
        beat_cnt_d = beat_cnt_q;
        gnt_c      = '0;
        case (state_q)
            IDLE: begin
                if (pick_found && !fifo_full) begin
                    gnt_c[pick_idx] = 1'b1;
                    owner_d         = pick_idx;
                    beat_cnt_d      = ONE_BEAT;
                    if (MAX_BURST == 1) rr_ptr_d = pick_next;
                    else                state_d  = BURST;
                end
            end
            BURST: begin
                if (req[owner_q]) begin
                    // A full FIFO stalls the burst: owner and beat count hold.
                    if (!fifo_full) begin
                        gnt_c[owner_q] = 1'b1;
                        beat_cnt_d     = beat_cnt_q + ONE_BEAT;
                        if (beat_cnt_q + ONE_BEAT == LAST_BEAT) begin
                            state_d  = IDLE;
                            rr_ptr_d = owner_next;
                        end
                    end
                end else begin
                    // Owner ran dry: release with a one-cycle bubble.
                    state_d  = IDLE;
                    rr_ptr_d = owner_next;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Arbiter state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            rr_ptr_q   <= '0;
            owner_q    <= '0;
            beat_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            owner_q    <= owner_d;
            beat_cnt_q <= beat_cnt_d;
        end
    end

    // Grants are combinational, so reset must mask them directly.
    assign gnt       = rst_n ? gnt_c : '0;
    assign fifo_w_en = |gnt;
    assign busy      = (state_q == BURST);
    assign owner     = owner_q;

    // Write-data mux: slice of the granted producer, zero when idle.
    always_comb begin
        fifo_data_in = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (gnt[i]) fifo_data_in = fifo_data_in | req_data[i*DATA_WIDTH +: DATA_WIDTH];
        end
    end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Bench for fifo_wr_arbiter: directed scenarios plus 10k random cycles against
// a behavioural burst/round-robin model and an attached depth-8 FIFO model.
module tb_fifo_wr_arbiter;

  localparam int N    = 4;
  localparam int DW   = 8;
  localparam int MAXB = 4;
  localparam int DEPTH = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [N-1:0]  req;
  logic [N*DW-1:0] req_data;
  logic [N-1:0]  gnt;
  logic          fifo_full;
  logic          fifo_w_en;
  logic [DW-1:0] fifo_data_in;
  logic          busy;
  logic [1:0]    owner;

  fifo_wr_arbiter #(.N_REQ(N), .DATA_WIDTH(DW), .MAX_BURST(MAXB)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req          (req),
    .req_data     (req_data),
    .gnt          (gnt),
    .fifo_full    (fifo_full),
    .fifo_w_en    (fifo_w_en),
    .fifo_data_in (fifo_data_in),
    .busy         (busy),
    .owner        (owner)
  );

  // clock / reset
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] dut_q[$];
  logic [DW-1:0] pend_data[N];
  int            last_g;

  // reference model: in_burst / owner / beats issued / round-robin pointer
  bit m_burst;
  int m_owner;
  int m_cnt;
  int m_ptr;
  bit waiting[N];
  int wait_beats[N];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_burst = 1'b0;
    m_owner = 0;
    m_cnt   = 0;
    m_ptr   = 0;
    for (int i = 0; i < N; i++) begin
      waiting[i]    = 1'b0;
      wait_beats[i] = 0;
    end
  endtask

  function automatic int model_pick(input logic [N-1:0] r, input bit full);
    if (full) return -1;
    if (m_burst) return r[2'(m_owner)] ? m_owner : -1;
    for (int k = 0; k < N; k++) begin
      if (r[2'((m_ptr + k) % N)]) return (m_ptr + k) % N;
    end
    return -1;
  endfunction

  task automatic model_update(input int g, input logic [N-1:0] r);
    if (!m_burst) begin
      if (g >= 0) begin
        m_owner = g;
        m_cnt   = 1;
        if (MAXB == 1) m_ptr = (g + 1) % N;
        else           m_burst = 1'b1;
      end
    end else if (g >= 0) begin
      m_cnt++;
      if (m_cnt == MAXB) begin
        m_burst = 1'b0;
        m_ptr   = (m_owner + 1) % N;
      end
    end else if (!r[2'(m_owner)]) begin
      m_burst = 1'b0;
      m_ptr   = (m_owner + 1) % N;
    end
  endtask

  // driver: one clock cycle with the given requests, optional forced full,
  // optional FIFO read; checks outputs against the model.
  task automatic step(input logic [N-1:0] r, input bit force_full, input bit pop_en);
    int       g;
    bit       full;
    logic [N-1:0] e_gnt;
    logic [DW-1:0] e_data;
    @(negedge clk);
    if (pop_en && dut_q.size() > 0) begin
      if (exp_q.size() == 0) check("fifo_extra_beat", 32'(1), 32'(0));
      else                   check("fifo_order", 32'(dut_q.pop_front()), 32'(exp_q.pop_front()));
    end
    full = force_full || (dut_q.size() >= DEPTH);
    fifo_full = full;
    req = r;
    for (int i = 0; i < N; i++) req_data[i*DW +: DW] = pend_data[i];
    #2;
    g = model_pick(r, full);
    e_gnt  = (g >= 0) ? (4'b0001 << g) : 4'b0000;
    e_data = (g >= 0) ? pend_data[2'(g)] : 8'h00;
    check("gnt", 32'(gnt), 32'(e_gnt));
    check("w_en", 32'(fifo_w_en), 32'(g >= 0));
    check("data", 32'(fifo_data_in), 32'(e_data));
    check("busy", 32'(busy), 32'(m_burst));
    check("owner", 32'(owner), 32'(m_owner));
    check("gnt_onehot", 32'($countones(gnt) <= 1), 32'(1));
    check("w_en_full", 32'(fifo_w_en & fifo_full), 32'(0));
    if (fifo_w_en) dut_q.push_back(fifo_data_in);
    if (g >= 0)    exp_q.push_back(e_data);
    // starvation tracking over continuously held requests
    for (int i = 0; i < N; i++) begin
      if (r[i]) begin
        if (!waiting[i]) begin
          waiting[i]    = 1'b1;
          wait_beats[i] = 0;
        end
      end else begin
        waiting[i] = 1'b0;
      end
    end
    if (g >= 0) begin
      if (waiting[2'(g)]) check("starve_bound", 32'(wait_beats[2'(g)] <= (N-1)*MAXB), 32'(1));
      waiting[2'(g)] = 1'b0;
      for (int i = 0; i < N; i++) if (i != g && waiting[i]) wait_beats[i]++;
    end
    model_update(g, r);
    last_g = g;
  endtask

  task automatic do_reset();
    @(negedge clk);
    req = '0;
    fifo_full = 1'b0;
    rst_n = 1'b0;
    #1;
    check("rst_gnt", 32'(gnt), 32'(0));
    check("rst_busy", 32'(busy), 32'(0));
    check("rst_owner", 32'(owner), 32'(0));
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  bit pending[N];

  initial begin
    rst_n = 1'b0;
    req = '0;
    req_data = '0;
    fifo_full = 1'b0;
    for (int i = 0; i < N; i++) pend_data[i] = '0;
    model_reset();
    repeat (2) @(negedge clk);
    check("init_gnt", 32'(gnt), 32'(0));
    check("init_w_en", 32'(fifo_w_en), 32'(0));
    check("init_data", 32'(fifo_data_in), 32'(0));
    check("init_busy", 32'(busy), 32'(0));
    check("init_owner", 32'(owner), 32'(0));
    rst_n = 1'b1;

    // asynchronous reset in the middle of a burst, req still held
    pend_data[1] = 8'h11;
    step(4'b0010, 1'b0, 1'b1);
    pend_data[1] = 8'h12;
    step(4'b0010, 1'b0, 1'b1);
    check("pre_rst_busy", 32'(busy), 32'(1));
    rst_n = 1'b0;
    #1;
    check("arst_gnt", 32'(gnt), 32'(0));
    check("arst_w_en", 32'(fifo_w_en), 32'(0));
    check("arst_busy", 32'(busy), 32'(0));
    check("arst_owner", 32'(owner), 32'(0));
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();

    // single producer: two bursts back to back
    do_reset();
    pend_data[2] = 8'h30;
    for (int k = 0; k < 6; k++) begin
      step(4'b0100, 1'b0, 1'b1);
      check("single_gnt", 32'(gnt), 32'(4'b0100));
      check("single_data", 32'(fifo_data_in), 32'h30 + 32'(k));
      check("single_busy", 32'(busy), (k == 0 || k == 4) ? 32'(0) : 32'(1));
      pend_data[2] = pend_data[2] + 8'h01;
    end
    step(4'b0000, 1'b0, 1'b1);

    // round-robin with everyone requesting
    do_reset();
    for (int i = 0; i < N; i++) pend_data[i] = 8'(8'h80 + 8'(i));
    for (int b = 0; b < 20; b++) begin
      logic [N-1:0] e;
      step(4'b1111, 1'b0, 1'b1);
      e = 4'b0001 << ((b / MAXB) % N);
      check("rr_gnt", 32'(gnt), 32'(e));
    end
    step(4'b0000, 1'b0, 1'b1);

    // early release by producer 1 while producer 3 waits
    do_reset();
    pend_data[1] = 8'h21;
    pend_data[3] = 8'h41;
    step(4'b1010, 1'b0, 1'b1);
    check("early_first", 32'(gnt), 32'(4'b0010));
    pend_data[1] = 8'h22;
    step(4'b1010, 1'b0, 1'b1);
    check("early_second", 32'(gnt), 32'(4'b0010));
    step(4'b1000, 1'b0, 1'b1);
    check("early_bubble", 32'(gnt), 32'(0));
    step(4'b1000, 1'b0, 1'b1);
    check("early_next", 32'(gnt), 32'(4'b1000));
    step(4'b0000, 1'b0, 1'b1);

    // full stall in the middle of a burst
    do_reset();
    pend_data[0] = 8'h50;
    for (int k = 0; k < 2; k++) begin
      step(4'b0001, 1'b0, 1'b1);
      check("stall_pre_gnt", 32'(gnt), 32'(4'b0001));
      pend_data[0] = pend_data[0] + 8'h01;
    end
    for (int k = 0; k < 3; k++) begin
      step(4'b0001, 1'b1, 1'b1);
      check("stall_gnt", 32'(gnt), 32'(0));
      check("stall_w_en", 32'(fifo_w_en), 32'(0));
      check("stall_busy", 32'(busy), 32'(1));
    end
    for (int k = 0; k < 2; k++) begin
      step(4'b0001, 1'b0, 1'b1);
      check("stall_resume_gnt", 32'(gnt), 32'(4'b0001));
      check("stall_resume_busy", 32'(busy), 32'(1));
      pend_data[0] = pend_data[0] + 8'h01;
    end
    step(4'b0001, 1'b0, 1'b1);
    check("stall_rearb_busy", 32'(busy), 32'(0));
    check("stall_rearb_gnt", 32'(gnt), 32'(4'b0001));
    step(4'b0000, 1'b0, 1'b1);

    // random producers, random forced full, random FIFO reads
    do_reset();
    for (int i = 0; i < N; i++) pending[i] = 1'b0;
    for (int c = 0; c < 10000; c++) begin
      logic [N-1:0] r;
      for (int i = 0; i < N; i++) begin
        if (!pending[i]) begin
          if ($urandom_range(0, 1) == 1) begin
            pending[i]   = 1'b1;
            pend_data[i] = 8'($urandom_range(0, 255));
          end
        end else if ($urandom_range(0, 19) == 0) begin
          pending[i] = 1'b0;
        end
        r[i] = pending[i];
      end
      step(r, $urandom_range(0, 9) == 0, $urandom_range(0, 9) < 6);
      if (last_g >= 0) pending[2'(last_g)] = 1'b0;
    end

    // drain the FIFO model and confirm nothing was lost or duplicated
    for (int k = 0; k < 4 * DEPTH && dut_q.size() > 0; k++) step(4'b0000, 1'b0, 1'b1);
    check("drain_dut_empty", 32'(dut_q.size()), 32'(0));
    check("drain_exp_empty", 32'(exp_q.size()), 32'(0));

    // final report
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
